// File: rtl/periwinkle_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default sizing.
package periwinkle_pkg;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLocked0  = 2'd1,
    StLocked1  = 2'd2
  } arb_state_e;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefLockMax = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter; the port that did not win last time wins a conflict.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port data-memory arbiter with round-robin fairness, bounded exclusive locks and a
// one-entry read-response tag that routes synchronous read data back to its requester.
module datamem_arbiter
  import periwinkle_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned LOCK_MAX = DefLockMax
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic              i_we_0,
  input  logic              i_we_1,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [31:0]       i_wdata_0,
  input  logic [31:0]       i_wdata_1,
  input  logic              i_lock_0,
  input  logic              i_lock_1,
  output logic              o_gnt_0,
  output logic              o_gnt_1,
  output logic              o_rvalid_0,
  output logic              o_rvalid_1,
  output logic [31:0]       o_rdata_0,
  output logic [31:0]       o_rdata_1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_tag_q, rd_tag_d;

  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       xfer;
  logic       sel;
  logic       sel_lock;

  rr_arb2 u_rr_arb2 (
    .req_i        ({i_req_1, i_req_0}),
    .last_grant_i (last_q),
    .gnt_o        (rr_gnt)
  );

  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      StUnlocked: gnt = rr_gnt;
      StLocked0:  gnt = {1'b0, i_req_0};
      StLocked1:  gnt = {i_req_1, 1'b0};
      default:    gnt = 2'b00;
    endcase
  end

  assign xfer     = |gnt;
  assign sel      = gnt[1];
  assign sel_lock = sel ? i_lock_1 : i_lock_0;

  assign o_gnt_0     = gnt[0];
  assign o_gnt_1     = gnt[1];
  assign o_mem_en    = xfer;
  assign o_mem_we    = xfer & (sel ? i_we_1 : i_we_0);
  assign o_mem_addr  = sel ? i_addr_1 : i_addr_0;
  assign o_mem_wdata = sel ? i_wdata_1 : i_wdata_0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = xfer ? sel : last_q;
    rd_pend_d = xfer & ~o_mem_we;
    rd_tag_d  = sel;
    unique case (state_q)
      StUnlocked: begin
        if (xfer && sel_lock) begin
          state_d = sel ? StLocked1 : StLocked0;
          cnt_d   = '0;
        end
      end
      StLocked0, StLocked1: begin
        // Timeout wins over the lock input and hands the next conflict to the other port.
        if (cnt_q == CntLast) begin
          state_d = StUnlocked;
          cnt_d   = '0;
          last_d  = (state_q == StLocked1);
        end else if (!((state_q == StLocked1) ? i_lock_1 : i_lock_0)) begin
          state_d = StUnlocked;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StUnlocked;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StUnlocked;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign o_rvalid_0 = rd_pend_q & ~rd_tag_q;
  assign o_rvalid_1 = rd_pend_q & rd_tag_q;
  assign o_rdata_0  = o_rvalid_0 ? i_mem_rdata : 32'h0;
  assign o_rdata_1  = o_rvalid_1 ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a small synchronous-read memory model.
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, we_0, we_1, lock_0, lock_1;
  logic [7:0]  addr_0, addr_1;
  logic [31:0] wdata_0, wdata_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  datamem_arbiter #(
    .ADDR_W   (8),
    .LOCK_MAX (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_0     (req_0),
    .i_req_1     (req_1),
    .i_we_0      (we_0),
    .i_we_1      (we_1),
    .i_addr_0    (addr_0),
    .i_addr_1    (addr_1),
    .i_wdata_0   (wdata_0),
    .i_wdata_1   (wdata_1),
    .i_lock_0    (lock_0),
    .i_lock_1    (lock_1),
    .o_gnt_0     (gnt_0),
    .o_gnt_1     (gnt_1),
    .o_rvalid_0  (rvalid_0),
    .o_rvalid_1  (rvalid_1),
    .o_rdata_0   (rdata_0),
    .o_rdata_1   (rdata_1),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial begin
    mem[0] <= 32'h1111_0000;
    mem[1] <= 32'h2222_0001;
    mem[2] <= 32'h0;
    mem_rdata <= 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {req_0, req_1, we_0, we_1, lock_0, lock_1} = '0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_rvalid0", rvalid_0, 0);
    chk("rst_rvalid1", rvalid_1, 0);
    chk("rst_mem_en", mem_en, 0);
    tick();
    rst = 1'b0;

    // Both ports read every cycle: grants alternate starting with port 0.
    req_0 = 1; addr_0 = 8'd0; req_1 = 1; addr_1 = 8'd1;
    settle();
    chk("alt_c0_gnt0", gnt_0, 1);
    chk("alt_c0_gnt1", gnt_1, 0);
    chk("alt_c0_addr", mem_addr, 0);
    tick(); settle();
    chk("alt_c1_gnt1", gnt_1, 1);
    chk("alt_c1_gnt0", gnt_0, 0);
    chk("alt_c1_rvalid0", rvalid_0, 1);
    chk("alt_c1_rdata0", rdata_0, 32'h1111_0000);
    chk("alt_c1_rvalid1", rvalid_1, 0);
    chk("alt_c1_rdata1", rdata_1, 0);
    tick(); settle();
    chk("alt_c2_gnt0", gnt_0, 1);
    chk("alt_c2_rvalid1", rvalid_1, 1);
    chk("alt_c2_rdata1", rdata_1, 32'h2222_0001);
    chk("alt_c2_rvalid0", rvalid_0, 0);
    tick(); settle();
    chk("alt_c3_gnt1", gnt_1, 1);
    chk("alt_c3_rdata0", rdata_0, 32'h1111_0000);
    tick();
    req_0 = 0; req_1 = 0;
    settle();
    chk("alt_tail_rdata1", rdata_1, 32'h2222_0001);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_we", mem_we, 0);

    // Port 0 writes, port 1 reads it back.
    tick();
    req_0 = 1; we_0 = 1; addr_0 = 8'd2; wdata_0 = 32'hDEAD_BEEF;
    settle();
    chk("wr_gnt0", gnt_0, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 2);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    req_0 = 0; we_0 = 0; req_1 = 1; addr_1 = 8'd2;
    settle();
    chk("rd1_gnt1", gnt_1, 1);
    chk("rd1_mem_we", mem_we, 0);
    tick();
    req_1 = 0;
    settle();
    chk("rd1_rvalid1", rvalid_1, 1);
    chk("rd1_rdata1", rdata_1, 32'hDEAD_BEEF);
    chk("rd1_rvalid0", rvalid_0, 0);
    chk("wr_no_rvalid_rdata0", rdata_0, 0);
    tick();
    req_0 = 1; addr_0 = 8'd2;
    settle();
    chk("rd0_gnt0", gnt_0, 1);
    tick();
    req_0 = 0;
    settle();
    chk("rd0_rdata0", rdata_0, 32'hDEAD_BEEF);

    // Port 1 locked read-modify-write while port 0 keeps requesting.
    tick();
    req_0 = 1; addr_0 = 8'd1;
    req_1 = 1; lock_1 = 1; addr_1 = 8'd0; we_1 = 0;
    settle();
    chk("lk_c0_gnt1", gnt_1, 1);
    chk("lk_c0_gnt0", gnt_0, 0);
    tick();
    req_1 = 0;
    settle();
    chk("lk_idle_gnt0", gnt_0, 0);
    chk("lk_rdata1", rdata_1, 32'h1111_0000);
    tick();
    req_1 = 1; we_1 = 1; wdata_1 = 32'hCAFE_F00D;
    settle();
    chk("lk_wr_gnt1", gnt_1, 1);
    chk("lk_wr_gnt0", gnt_0, 0);
    chk("lk_wr_wdata", mem_wdata, 32'hCAFE_F00D);
    tick();
    req_1 = 0; we_1 = 0; lock_1 = 0;
    settle();
    chk("lk_drop_gnt0", gnt_0, 0);
    tick(); settle();
    chk("lk_after_gnt0", gnt_0, 1);
    chk("lk_after_addr", mem_addr, 1);
    tick();
    req_0 = 0; req_1 = 1; addr_1 = 8'd0;
    settle();
    chk("lk_after_rdata0", rdata_0, 32'h2222_0001);
    chk("rb_gnt1", gnt_1, 1);
    tick();

    // Port 0 holds a lock past the limit while port 1 keeps requesting.
    req_1 = 1; addr_1 = 8'd1;
    req_0 = 1; lock_0 = 1; addr_0 = 8'd0;
    settle();
    chk("rb_rdata1", rdata_1, 32'hCAFE_F00D);
    chk("to_enter_gnt0", gnt_0, 1);
    chk("to_enter_gnt1", gnt_1, 0);
    for (int i = 0; i < 16; i++) begin
      tick(); settle();
      chk("to_locked_gnt0", gnt_0, 1);
      chk("to_locked_gnt1", gnt_1, 0);
    end
    tick(); settle();
    chk("to_release_gnt1", gnt_1, 1);
    chk("to_release_gnt0", gnt_0, 0);
    tick(); settle();
    chk("to_relock_gnt0", gnt_0, 1);
    tick();
    req_0 = 0; req_1 = 0; lock_0 = 0;

    // Reset while a port 0 read is pending.
    tick();
    req_0 = 1; addr_0 = 8'd2;
    settle();
    chk("rr_gnt0", gnt_0, 1);
    tick();
    req_0 = 0; rst = 1;
    settle();
    chk("rr_rvalid0_a", rvalid_0, 0);
    tick(); settle();
    chk("rr_rvalid0_b", rvalid_0, 0);
    tick();
    rst = 0; req_0 = 1; req_1 = 1; addr_0 = 8'd0; addr_1 = 8'd1;
    settle();
    chk("post_rst_gnt0", gnt_0, 1);
    chk("post_rst_gnt1", gnt_1, 0);
    chk("post_rst_rvalid0", rvalid_0, 0);
    tick();
    req_0 = 0; req_1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
